// File: rtl/useq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : useq_ctrl
//  Brief    : Microprogrammed control sequencer with a loadable control
//             store, loadable dispatch table, micro-subroutine return stack
//             and memory wait state. Drives the multicycle datapath controls.
//  Revision : 1.0 - initial release
// ============================================================================
module useq_ctrl #(
    parameter int CW_W    = 12,   // datapath control bits per microword
    parameter int ADDR_W  = 5,    // microaddress width
    parameter int KEY_W   = 4,    // dispatch key width, must be <= ADDR_W
    parameter int STACK_D = 4     // return-stack depth, >= 1
) (
    input  logic                     clk,
    input  logic                     reset,       // async, active-low
    input  logic                     run,
    input  logic [KEY_W-1:0]         disp_key,
    input  logic                     mem_ready,
    input  logic                     load_en,
    input  logic                     load_sel,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [CW_W+ADDR_W+2:0]   load_data,
    output logic [CW_W-1:0]          ctrl,
    output logic [ADDR_W-1:0]        uaddr,
    output logic                     err
);

    localparam int UW    = CW_W + ADDR_W + 3;
    localparam int SPW   = $clog2(STACK_D + 1);
    // Stack storage is rounded up to a power of two so the pointer can index
    // it directly; entries at or beyond STACK_D are never written.
    localparam int STK_N = 1 << SPW;

    localparam logic [2:0]     c_SEQ   = 3'd0;
    localparam logic [2:0]     c_JMP   = 3'd1;
    localparam logic [2:0]     c_DISP  = 3'd2;
    localparam logic [2:0]     c_CALL  = 3'd3;
    localparam logic [2:0]     c_RET   = 3'd4;
    localparam logic [2:0]     c_WAIT  = 3'd5;
    localparam logic [2:0]     c_FETCH = 3'd6;
    localparam logic [SPW-1:0] c_SP_FULL = SPW'(STACK_D);

    logic [UW-1:0]     r_store [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] r_dtab  [0:(1<<KEY_W)-1];
    logic [ADDR_W-1:0] r_stack [0:STK_N-1];

    logic [ADDR_W-1:0] r_uaddr;
    logic [SPW-1:0]    r_sp;
    logic              r_err;

    logic [UW-1:0]     w_word;
    logic [2:0]        w_seq;
    logic [ADDR_W-1:0] w_next;
    logic [CW_W-1:0]   w_cw;
    logic [ADDR_W-1:0] w_inc;
    logic [SPW-1:0]    w_sp_dec;
    logic [ADDR_W-1:0] w_nxt_uaddr;
    logic [SPW-1:0]    w_nxt_sp;
    logic              w_push;
    logic              w_set_err;

    // Current microword fields; ctrl is purely combinational from uaddr.
    assign w_word   = r_store[r_uaddr];
    assign w_seq    = w_word[UW-1 -: 3];
    assign w_next   = w_word[CW_W +: ADDR_W];
    assign w_cw     = w_word[CW_W-1:0];
    assign w_inc    = r_uaddr + ADDR_W'(1);
    assign w_sp_dec = r_sp - SPW'(1);

    assign ctrl  = run ? w_cw : '0;
    assign uaddr = r_uaddr;
    assign err   = r_err;

    // Next-address, stack-pointer and error selection from the seq field.
    always_comb begin
        w_nxt_uaddr = w_inc;
        w_nxt_sp    = r_sp;
        w_push      = 1'b0;
        w_set_err   = 1'b0;
        case (w_seq)
            c_SEQ:   w_nxt_uaddr = w_inc;
            c_JMP:   w_nxt_uaddr = w_next;
            c_DISP:  w_nxt_uaddr = r_dtab[disp_key];
            c_CALL: begin
                // A full stack drops the return address but still jumps.
                w_nxt_uaddr = w_next;
                if (r_sp == c_SP_FULL) begin
                    w_set_err = 1'b1;
                end else begin
                    w_push   = 1'b1;
                    w_nxt_sp = r_sp + SPW'(1);
                end
            end
            c_RET: begin
                if (r_sp == '0) begin
                    w_nxt_uaddr = '0;
                    w_set_err   = 1'b1;
                end else begin
                    w_nxt_uaddr = r_stack[w_sp_dec];
                    w_nxt_sp    = w_sp_dec;
                end
            end
            c_WAIT:  w_nxt_uaddr = mem_ready ? w_inc : r_uaddr;
            c_FETCH: w_nxt_uaddr = '0;
            default: begin
                // Reserved encoding: refetch and flag the fault.
                w_nxt_uaddr = '0;
                w_set_err   = 1'b1;
            end
        endcase
    end

    // Sequencer state: async reset, halt forces a restart from address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uaddr <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else if (!run) begin
            r_uaddr <= '0;
            r_sp    <= '0;
        end else begin
            r_uaddr <= w_nxt_uaddr;
            r_sp    <= w_nxt_sp;
            r_err   <= r_err | w_set_err;
        end
    end

    // Return-address stack storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (run && w_push) begin
            r_stack[r_sp] <= w_inc;
        end
    end

    // Control store and dispatch table writes, accepted only while halted.
    always_ff @(posedge clk) begin
        if (!run && load_en) begin
            if (!load_sel) begin
                r_store[load_addr] <= load_data;
            end else begin
                r_dtab[load_addr[KEY_W-1:0]] <= load_data[ADDR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_useq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_useq_ctrl
//  Brief    : Directed self-checking bench for useq_ctrl (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_useq_ctrl;

    localparam int CW_W = 12;
    localparam int ADDR_W = 5;
    localparam int KEY_W = 4;
    localparam int UW = CW_W + ADDR_W + 3;

    localparam int SEQ = 0, JMP = 1, DISP = 2, CALL = 3, RET = 4, WAIT = 5, FETCH = 6, RSVD = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic [KEY_W-1:0]  disp_key = '0;
    logic              mem_ready = 1'b0;
    logic              load_en = 1'b0;
    logic              load_sel = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [UW-1:0]     load_data = '0;
    logic [CW_W-1:0]   ctrl;
    logic [ADDR_W-1:0] uaddr;
    logic              err;

    int total = 0;
    int bad = 0;

    useq_ctrl #(.CW_W(CW_W), .ADDR_W(ADDR_W), .KEY_W(KEY_W), .STACK_D(4)) dut (
        .clk(clk), .reset(reset), .run(run), .disp_key(disp_key),
        .mem_ready(mem_ready), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data),
        .ctrl(ctrl), .uaddr(uaddr), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [UW-1:0] mw(input int s, input int n, input int c);
        return {3'(s), 5'(n), 12'(c)};
    endfunction

    // Write one word while halted (called at a falling edge).
    task automatic ld(input logic sel, input int a, input logic [UW-1:0] d);
        load_sel  = sel;
        load_addr = 5'(a);
        load_data = d;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic halt();
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd0) begin bad++; $display("FAIL reset_uaddr actual=%0d required=0", uaddr); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err actual=%0b required=0", err); end
        total++; if (ctrl !== 12'h000) begin bad++; $display("FAIL reset_ctrl_halted actual=%h required=000", ctrl); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int eu[4] = '{0, 1, 0, 1};
        int ec[4] = '{'h001, 'h002, 'h001, 'h002};
        ld(0, 0, mw(SEQ, 0, 'h001));
        ld(0, 1, mw(JMP, 0, 'h002));
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (uaddr !== 5'(eu[i])) begin bad++; $display("FAIL basic_uaddr[%0d] actual=%0d required=%0d", i, uaddr, eu[i]); end
            total++; if (ctrl !== 12'(ec[i])) begin bad++; $display("FAIL basic_ctrl[%0d] actual=%h required=%h", i, ctrl, ec[i]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err[%0d] actual=%0b required=0", i, err); end
            @(negedge clk);
        end
        halt();
    endtask

    task automatic test_dispatch();
        int eu[4] = '{0, 1, 7, 0};
        int ec[4] = '{'h001, 'h003, 'h0F0, 'h001};
        ld(1, 'hA, UW'(7));
        ld(0, 7, mw(FETCH, 0, 'h0F0));
        ld(0, 1, mw(DISP, 0, 'h003));
        disp_key = 4'hA;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (uaddr !== 5'(eu[i])) begin bad++; $display("FAIL disp_uaddr[%0d] actual=%0d required=%0d", i, uaddr, eu[i]); end
            total++; if (ctrl !== 12'(ec[i])) begin bad++; $display("FAIL disp_ctrl[%0d] actual=%h required=%h", i, ctrl, ec[i]); end
            @(negedge clk);
        end
        halt();
    endtask

    task automatic test_call_ret();
        int eu[6] = '{0, 1, 2, 20, 3, 0};
        int ec[6] = '{'h001, 'h011, 'h022, 'h014, 'h033, 'h001};
        int nu[14] = '{0, 1, 8, 16, 24, 26, 28, 30, 27, 25, 17, 9, 0, 1};
        int ne[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        ld(0, 1, mw(SEQ, 0, 'h011));
        ld(0, 2, mw(CALL, 20, 'h022));
        ld(0, 20, mw(RET, 0, 'h014));
        ld(0, 3, mw(FETCH, 0, 'h033));
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (uaddr !== 5'(eu[i])) begin bad++; $display("FAIL call_uaddr[%0d] actual=%0d required=%0d", i, uaddr, eu[i]); end
            total++; if (ctrl !== 12'(ec[i])) begin bad++; $display("FAIL call_ctrl[%0d] actual=%h required=%h", i, ctrl, ec[i]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL call_err[%0d] actual=%0b required=0", i, err); end
            @(negedge clk);
        end
        halt();
        // Five nested calls against a four-deep stack, then unwind.
        ld(0, 1, mw(JMP, 8, 'h011));
        ld(0, 8, mw(CALL, 16, 8));
        ld(0, 9, mw(RET, 0, 9));
        ld(0, 16, mw(CALL, 24, 16));
        ld(0, 17, mw(RET, 0, 17));
        ld(0, 24, mw(CALL, 26, 24));
        ld(0, 25, mw(RET, 0, 25));
        ld(0, 26, mw(CALL, 28, 26));
        ld(0, 27, mw(RET, 0, 27));
        ld(0, 28, mw(CALL, 30, 28));
        ld(0, 29, mw(RET, 0, 29));
        ld(0, 30, mw(RET, 0, 30));
        run = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            total++; if (uaddr !== 5'(nu[i])) begin bad++; $display("FAIL nest_uaddr[%0d] actual=%0d required=%0d", i, uaddr, nu[i]); end
            total++; if (err !== 1'(ne[i])) begin bad++; $display("FAIL nest_err[%0d] actual=%0b required=%0d", i, err, ne[i]); end
            @(negedge clk);
        end
        halt();
    endtask

    task automatic test_wait();
        int eu[8] = '{0, 1, 4, 4, 4, 4, 5, 0};
        int ec[8] = '{'h001, 'h011, 'h044, 'h044, 'h044, 'h044, 'h055, 'h001};
        int mr[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        ld(0, 1, mw(JMP, 4, 'h011));
        ld(0, 4, mw(WAIT, 0, 'h044));
        ld(0, 5, mw(FETCH, 0, 'h055));
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'(mr[i]);
            #1;
            total++; if (uaddr !== 5'(eu[i])) begin bad++; $display("FAIL wait_uaddr[%0d] actual=%0d required=%0d", i, uaddr, eu[i]); end
            total++; if (ctrl !== 12'(ec[i])) begin bad++; $display("FAIL wait_ctrl[%0d] actual=%h required=%h", i, ctrl, ec[i]); end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        halt();
    endtask

    task automatic test_reserved();
        int eu[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int ee[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        ld(0, 1, mw(SEQ, 0, 'h011));
        ld(0, 2, mw(SEQ, 0, 'h022));
        ld(0, 3, mw(RSVD, 0, 'h033));
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (uaddr !== 5'(eu[i])) begin bad++; $display("FAIL rsvd_uaddr[%0d] actual=%0d required=%0d", i, uaddr, eu[i]); end
            total++; if (err !== 1'(ee[i])) begin bad++; $display("FAIL rsvd_err[%0d] actual=%0b required=%0d", i, err, ee[i]); end
            @(negedge clk);
        end
        halt();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rsvd_err_sticky_halt actual=%0b required=1", err); end
    endtask

    task automatic test_reset_halt();
        @(negedge clk);
        ld(0, 1, mw(JMP, 9, 'h011));
        ld(0, 9, mw(JMP, 9, 'h099));
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd9) begin bad++; $display("FAIL rh_pre_uaddr actual=%0d required=9", uaddr); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rh_pre_err actual=%0b required=1", err); end
        // Async reset in the middle of the low clock phase.
        #1 reset = 1'b0;
        #1;
        total++; if (uaddr !== 5'd0) begin bad++; $display("FAIL rh_async_uaddr actual=%0d required=0", uaddr); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rh_async_err actual=%0b required=0", err); end
        total++; if (ctrl !== 12'h001) begin bad++; $display("FAIL rh_async_ctrl actual=%h required=001", ctrl); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd9) begin bad++; $display("FAIL rh_rerun_uaddr actual=%0d required=9", uaddr); end
        @(negedge clk);
        run = 1'b0;
        #1;
        total++; if (ctrl !== 12'h000) begin bad++; $display("FAIL rh_halt_ctrl actual=%h required=000", ctrl); end
        total++; if (uaddr !== 5'd9) begin bad++; $display("FAIL rh_halt_uaddr_before_edge actual=%0d required=9", uaddr); end
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd0) begin bad++; $display("FAIL rh_halt_uaddr actual=%0d required=0", uaddr); end
        // Load strobes while running must be ignored.
        @(negedge clk);
        run       = 1'b1;
        load_en   = 1'b1;
        load_sel  = 1'b0;
        load_addr = 5'd9;
        load_data = mw(FETCH, 0, 'hBAD);
        @(negedge clk);
        load_sel  = 1'b1;
        load_addr = 5'hA;
        load_data = UW'(3);
        @(negedge clk);
        load_en = 1'b0;
        #1;
        total++; if (uaddr !== 5'd9) begin bad++; $display("FAIL rh_ld_uaddr actual=%0d required=9", uaddr); end
        total++; if (ctrl !== 12'h099) begin bad++; $display("FAIL rh_ld_ctrl actual=%h required=099", ctrl); end
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd9) begin bad++; $display("FAIL rh_ld_store_kept actual=%0d required=9", uaddr); end
        @(negedge clk);
        halt();
        // Dispatch entry 0xA must still point at 7.
        ld(0, 1, mw(DISP, 0, 'h011));
        disp_key = 4'hA;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (uaddr !== 5'd7) begin bad++; $display("FAIL rh_ld_dtab_kept actual=%0d required=7", uaddr); end
        total++; if (ctrl !== 12'h0F0) begin bad++; $display("FAIL rh_ld_dtab_ctrl actual=%h required=0f0", ctrl); end
        @(negedge clk);
        halt();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dispatch();
        test_call_ret();
        do_reset();
        test_wait();
        test_reserved();
        test_reset_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/useq_ctrl.md
# useq_ctrl

Parametrised microprogrammed control sequencer for the multicycle ARM datapath. It replaces the fixed 16-entry control ROM and sequencer with:
- a run-time loadable control store of configurable depth and control-word width;
- a loadable dispatch table indexed by a decode key;
- a micro-subroutine call/return stack;
- a memory wait state.

It sits between the instruction register/decoder and the datapath control inputs.

## Interface
Parameters:
- CW_W, 12, number of datapath control bits per microword
- ADDR_W, 5, microaddress width; control store holds 2**ADDR_W words
- KEY_W, 4, dispatch key width; dispatch table holds 2**KEY_W entries; KEY_W <= ADDR_W required
- STACK_D, 4, return-stack depth (>= 1)
- Derived: UW = CW_W + ADDR_W + 3 (microword width)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- run  in  1  1 = sequencer executes; 0 = halted/load mode
- disp_key  in  KEY_W  decode key, e.g. {Op, Funct bits}, from decoder
- mem_ready  in  1  memory ready, used by WAIT
- load_en  in  1  write strobe for control store/dispatch table
- load_sel  in  1  0 = control store, 1 = dispatch table
- load_addr  in  ADDR_W  write address; dispatch writes use low KEY_W bits
- load_data  in  UW  write data; dispatch writes use low ADDR_W bits
- ctrl  out  CW_W  datapath control bits
- uaddr  out  ADDR_W  current microaddress
- err  out  1  sticky sequencing error flag

## Operation
- Microword layout, MSB to LSB: seq[2:0], next[ADDR_W-1:0], cw[CW_W-1:0].
- ctrl equals cw of store[uaddr] when run=1, and 0 when run=0. It is combinational from uaddr.
- Next-address selection by seq, applied on each clock edge while run=1:
  - 0 SEQ: uaddr+1, wrapping modulo 2**ADDR_W
  - 1 JMP: next
  - 2 DISP: dtab[disp_key]
  - 3 CALL: push uaddr+1 (wrapping), then go to next
  - 4 RET: pop, then go to the popped address
  - 5 WAIT: hold uaddr while mem_ready=0; uaddr+1 when mem_ready=1
  - 6 FETCH: 0
  - 7 reserved: behaves as FETCH and sets err
- CALL with stack full (sp=STACK_D): the push is discarded, the jump to next is still taken, and err is set.
- RET with stack empty (sp=0): go to 0 and set err.
- err is cleared only by reset.
- Halt (run=0):
  - uaddr is forced to 0 and sp to 0 on the next edge.
  - A load_en pulse writes load_data to the selected array at that edge.
  - load_en while run=1 is ignored; no array changes.
- Reset clears uaddr, sp and err. Array contents are not cleared.
- After reset, execution starts at microaddress 0, which is the fetch microinstruction.

## Timing
- One microinstruction per cycle except WAIT.
- disp_key and mem_ready are sampled at the edge that ends a DISP or WAIT cycle; they must be stable in that cycle.
- A loaded word is visible to sequencing from the edge after the write.
- Deasserting run mid-program: at the next edge uaddr=0, sp=0, ctrl=0. Asserting run restarts at 0.
- Asynchronous reset mid-operation: uaddr, sp and err go to 0 immediately, without waiting for an edge. Removal is synchronised by the system reset generator.
- Reset output values: uaddr=0, err=0, ctrl=cw of store[0] when run=1, else 0.

## Test plan
- Load/run basic flow, with defaults:
  - Stimulus: load store[0]={SEQ,0,0x001}, store[1]={JMP,0,0x002}, then set run=1.
  - Required: uaddr sequence 0,1,0,1; ctrl sequence 0x001,0x002,...; err=0.
- Dispatch:
  - Stimulus: dtab[0xA]=7, store[7]={FETCH,0,0x0F0}, store[1]={DISP,..}, disp_key=0xA.
  - Required: uaddr sequence 0,1,7,0; ctrl=0x0F0 at uaddr 7.
- Call/return:
  - Stimulus: store[2]={CALL,20,..}, store[20]={RET,..}.
  - Required: uaddr sequence 2,20,3.
  - Then nest 5 CALLs, one more than STACK_D=4.
  - Required: err=1 after the 5th CALL; the 5th RET goes to 0.
- WAIT:
  - Stimulus: store[4]={WAIT,..}, mem_ready low for 3 cycles, then high.
  - Required: uaddr=4 for 4 cycles, then 5; ctrl held at store[4].cw throughout.
- Reserved op and empty RET:
  - Stimulus: seq=7 at address 3.
  - Required: next uaddr=0, err=1, and err stays 1 until reset.
- Reset/halt mid-operation:
  - Stimulus: assert reset low mid-cycle while uaddr=9.
  - Required: uaddr=0 and err=0 before the next edge.
  - Stimulus: set run=0 while uaddr=9.
  - Required: ctrl=0 immediately; uaddr=0 at the next edge.
  - Stimulus: load_en while run=1.
  - Required: arrays unchanged.
